// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader_pkg
//  Description : Constants and FSM state encoding shared by the program loader
//                and the instruction fetch block.
//  Contents    : c_line_length    - default instruction-buffer depth (words)
//                c_bytes_per_word - default host bytes per instruction
//                c_instr_w        - instruction width in bits
//                c_byte_w         - host byte width in bits
//                c_count_w        - width of the word_count request field
//                loader_state_t   - loader FSM states
//                count_exceeds()  - length-limit comparison helper
//  Revision    : 1.0  initial release
// ============================================================================
package program_loader_pkg;

   localparam int c_line_length    = 1024;
   localparam int c_bytes_per_word = 4;
   localparam int c_instr_w        = 32;
   localparam int c_byte_w         = 8;
   localparam int c_count_w        = 11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ASSEMBLE = 2'd1,
      ST_EMIT     = 2'd2,
      ST_DONE     = 2'd3
   } loader_state_t;

   // True when a requested program length does not fit in the buffer.
   function automatic logic count_exceeds(input logic [0:c_count_w-1] count,
                                          input logic [0:c_count_w-1] limit);
      return (count > limit);
   endfunction

endpackage
`default_nettype wire

// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader_if
//  Description : Host / instruction-buffer / core-control bundle of the
//                program loader.
//  Signals     : start, word_count          - load request
//                host_byte, host_valid,
//                host_ready                  - host byte stream handshake
//                load_en, instruction_out    - instruction-buffer write port
//                core_stall, load_done,
//                err_len                     - core control and status
//  Modports    : master - requester / host / consumer side
//                slave  - the loader itself
//  Revision    : 1.0  initial release
// ============================================================================
interface program_loader_if;
   import program_loader_pkg::*;

   logic                  start;
   logic [0:c_count_w-1]  word_count;
   logic [0:c_byte_w-1]   host_byte;
   logic                  host_valid;
   logic                  host_ready;
   logic                  load_en;
   logic [0:c_instr_w-1]  instruction_out;
   logic                  core_stall;
   logic                  load_done;
   logic                  err_len;

   modport master (
      output start,
      output word_count,
      output host_byte,
      output host_valid,
      input  host_ready,
      input  load_en,
      input  instruction_out,
      input  core_stall,
      input  load_done,
      input  err_len
   );

   modport slave (
      input  start,
      input  word_count,
      input  host_byte,
      input  host_valid,
      output host_ready,
      output load_en,
      output instruction_out,
      output core_stall,
      output load_done,
      output err_len
   );

endinterface
`default_nettype wire

// File: rtl/program_loader_byte_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader_byte_assembler
//  Description : Big-endian byte-to-instruction shift register with a byte
//                counter. The first byte of a word ends up in bits [0:7].
//  Ports       : clk           - clock
//                rst           - asynchronous active-low reset
//                clear         - restart word assembly (new load)
//                shift_en      - a host byte is transferred this cycle
//                byte_in       - host byte
//                word_next     - word value including byte_in
//                word_complete - this transfer carries the last byte of a word
//  Revision    : 1.0  initial release
// ============================================================================
module program_loader_byte_assembler
   import program_loader_pkg::*;
#(
   parameter int BYTES_PER_WORD = c_bytes_per_word
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   input  wire logic                 clear,
   input  wire logic                 shift_en,
   input  wire logic [0:c_byte_w-1]  byte_in,
   output logic      [0:c_instr_w-1] word_next,
   output logic                      word_complete
);

   localparam int c_cnt_w = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam logic [c_cnt_w-1:0] c_last_byte = c_cnt_w'(BYTES_PER_WORD - 1);

   logic [0:c_instr_w-1] r_word;
   logic [c_cnt_w-1:0]   r_byte_cnt;
   logic                 w_last_byte;

   // Older bytes move towards bit 0, the new byte lands in the low-order lane.
   assign word_next     = {r_word[c_byte_w:c_instr_w-1], byte_in};
   assign w_last_byte   = (r_byte_cnt == c_last_byte);
   assign word_complete = shift_en && w_last_byte;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_word     <= '0;
         r_byte_cnt <= '0;
      end else if (clear) begin
         r_word     <= '0;
         r_byte_cnt <= '0;
      end else if (shift_en) begin
         r_word     <= word_next;
         r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + c_cnt_w'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Loads a program from a byte-wide host stream into the
//                instruction buffer, one 32-bit word per load_en strobe, while
//                stalling the core.
//  Ports       : clk  - clock, all state updates on the rising edge
//                rst  - asynchronous active-low reset
//                bus  - program_loader_if.slave:
//                       start / word_count       load request
//                       host_byte / host_valid /
//                       host_ready               host stream handshake
//                       load_en / instruction_out buffer write port
//                       core_stall / load_done /
//                       err_len                  core control and status
//  Revision    : 1.0  initial release
// ============================================================================
module program_loader
   import program_loader_pkg::*;
#(
   parameter int LINE_LENGTH    = c_line_length,
   parameter int BYTES_PER_WORD = c_bytes_per_word
) (
   input  wire logic         clk,
   input  wire logic         rst,
   program_loader_if.slave   bus
);

   localparam logic [0:c_count_w-1] c_line_len = c_count_w'(LINE_LENGTH);

   loader_state_t         r_state;
   loader_state_t         w_state_next;

   logic [0:c_count_w-1]  r_count_cap;
   logic [0:c_count_w-1]  r_word_cnt;
   logic [0:c_count_w-1]  w_word_cnt_inc;
   logic                  r_err_len;
   logic [0:c_instr_w-1]  r_instr;

   logic                  w_start_acc;
   logic                  w_len_over;
   logic                  w_host_ready;
   logic                  w_load_en;
   logic                  w_shift;
   logic                  w_word_complete;
   logic [0:c_instr_w-1]  w_word_next;

   assign w_len_over     = count_exceeds(bus.word_count, c_line_len);
   assign w_word_cnt_inc = r_word_cnt + c_count_w'(1);

   // ------------------------------------------------------------------------
   // Byte assembly
   // ------------------------------------------------------------------------
   program_loader_byte_assembler #(
      .BYTES_PER_WORD (BYTES_PER_WORD)
   ) u_byte_assembler (
      .clk           (clk),
      .rst           (rst),
      .clear         (w_start_acc),
      .shift_en      (w_shift),
      .byte_in       (bus.host_byte),
      .word_next     (w_word_next),
      .word_complete (w_word_complete)
   );

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next state and outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_start_acc  = 1'b0;
      w_host_ready = 1'b0;
      w_load_en    = 1'b0;
      w_shift      = 1'b0;

      case (r_state)
         ST_IDLE, ST_DONE: begin
            // Requests are only honoured between loads.
            if (bus.start) begin
               w_start_acc = 1'b1;
               if (bus.word_count == '0 || w_len_over) begin
                  w_state_next = ST_DONE;
               end else begin
                  w_state_next = ST_ASSEMBLE;
               end
            end
         end

         ST_ASSEMBLE: begin
            w_host_ready = 1'b1;
            w_shift      = bus.host_valid;
            if (w_word_complete) begin
               w_state_next = ST_EMIT;
            end
         end

         ST_EMIT: begin
            // Host is throttled here so no byte is consumed during the strobe.
            w_load_en = 1'b1;
            if (w_word_cnt_inc < r_count_cap) begin
               w_state_next = ST_ASSEMBLE;
            end else begin
               w_state_next = ST_DONE;
            end
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Counters, status and output word
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count_cap <= '0;
         r_word_cnt  <= '0;
         r_err_len   <= 1'b0;
         r_instr     <= '0;
      end else begin
         if (w_start_acc) begin
            r_count_cap <= bus.word_count;
            r_word_cnt  <= '0;
            r_err_len   <= w_len_over;
         end else if (r_state == ST_EMIT) begin
            r_word_cnt  <= w_word_cnt_inc;
         end

         // Captured on the last-byte transfer so the word is presented in
         // EMIT and then held until the next word completes.
         if (w_word_complete) begin
            r_instr <= w_word_next;
         end
      end
   end

   assign bus.host_ready      = w_host_ready;
   assign bus.load_en         = w_load_en;
   assign bus.instruction_out = r_instr;
   assign bus.core_stall      = (r_state == ST_ASSEMBLE) || (r_state == ST_EMIT);
   assign bus.load_done       = (r_state == ST_DONE) && !r_err_len;
   assign bus.err_len         = r_err_len;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_loader
//  Description : Self-checking bench for program_loader: table of single-load
//                vectors, reset-mid-load sequence and a full-length random load.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_program_loader;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   program_loader_if bus ();

   program_loader u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------------------------------------------------------------
   // Bookkeeping
   // ---------------------------------------------------------------------
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------
   // Monitor: collects written words and checks strobe timing
   // (a strobe is due exactly one cycle after every 4th transferred byte).
   // ---------------------------------------------------------------------
   logic [31:0] got_q[$];
   int lat_err  = 0;
   int stall_hi = 0;
   int stall_lo = 0;
   int ready_hi = 0;
   int xfer_cnt = 0;
   bit exp_emit = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         xfer_cnt <= 0;
         exp_emit <= 1'b0;
         if (bus.load_en !== 1'b0) lat_err <= lat_err + 1;
      end else begin
         if (bus.load_en === 1'b1) got_q.push_back(bus.instruction_out);
         if (bus.load_en !== exp_emit) lat_err <= lat_err + 1;
         if (bus.core_stall === 1'b1) stall_hi <= stall_hi + 1;
         else                         stall_lo <= stall_lo + 1;
         if (bus.host_ready === 1'b1) ready_hi <= ready_hi + 1;
         if (bus.start && !bus.core_stall) begin
            xfer_cnt <= 0;
            exp_emit <= 1'b0;
         end else if (bus.host_valid && bus.host_ready) begin
            xfer_cnt <= xfer_cnt + 1;
            exp_emit <= ((xfer_cnt + 1) % 4 == 0);
         end else begin
            exp_emit <= 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------
   // Reference model helpers
   // ---------------------------------------------------------------------
   function automatic int model_words(input int unsigned wc);
      return (wc > 1024) ? 0 : int'(wc);
   endfunction

   logic [31:0] exp_words[$];

   task automatic do_start(input int unsigned wc);
      bus.word_count = 11'(wc);
      bus.start      = 1'b1;
      step();
      bus.start      = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited;
      bus.host_valid = 1'b0;
      repeat (gap) step();
      bus.host_valid = 1'b1;
      bus.host_byte  = b;
      waited = 0;
      while (bus.host_ready !== 1'b1 && waited < 64) begin
         step();
         waited++;
      end
      if (bus.host_ready !== 1'b1) begin
         check("host_ready_timeout", {63'd0, bus.host_ready}, 64'd1);
      end else begin
         step();
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8], gap);
   endtask

   task automatic hold_then_idle();
      bus.host_valid = 1'b1;
      bus.host_byte  = 8'hEE;
      repeat (3) step();
      bus.host_valid = 1'b0;
   endtask

   task automatic wait_pulses(input int target);
      int w;
      w = 0;
      while (got_q.size() < target && w < 20) begin
         step();
         w++;
      end
      repeat (3) step();
   endtask

   // ---------------------------------------------------------------------
   // Vector table
   // ---------------------------------------------------------------------
   typedef struct {
      int unsigned wc;
      logic [31:0] w0;
      logic [31:0] w1;
      int          gap;
      int          exp_pulses;
      logic        exp_done;
      logic        exp_err;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int base, lat0, sh0, rh0, s0, s1, nsend;
      logic [31:0] w;

      vecs[0] = '{wc:2,    w0:32'h12345678, w1:32'h9ABCDEF0, gap:0, exp_pulses:2, exp_done:1'b1, exp_err:1'b0};
      vecs[1] = '{wc:0,    w0:32'h0,        w1:32'h0,        gap:0, exp_pulses:0, exp_done:1'b1, exp_err:1'b0};
      vecs[2] = '{wc:1025, w0:32'h0,        w1:32'h0,        gap:0, exp_pulses:0, exp_done:1'b0, exp_err:1'b1};
      vecs[3] = '{wc:1,    w0:32'hDEADBEEF, w1:32'h0,        gap:5, exp_pulses:1, exp_done:1'b1, exp_err:1'b0};
      vecs[4] = '{wc:2047, w0:32'h0,        w1:32'h0,        gap:0, exp_pulses:0, exp_done:1'b0, exp_err:1'b1};
      vecs[5] = '{wc:1,    w0:32'h00000000, w1:32'h0,        gap:1, exp_pulses:1, exp_done:1'b1, exp_err:1'b0};
      vecs[6] = '{wc:2,    w0:32'hFFFFFFFF, w1:32'h00000001, gap:2, exp_pulses:2, exp_done:1'b1, exp_err:1'b0};

      bus.start      = 1'b0;
      bus.word_count = '0;
      bus.host_byte  = '0;
      bus.host_valid = 1'b0;

      // ---------------- reset state ----------------
      rst = 1'b0;
      repeat (3) step();
      check("rst_host_ready", {63'd0, bus.host_ready}, 64'd0);
      check("rst_load_en",    {63'd0, bus.load_en},    64'd0);
      check("rst_instr",      {32'd0, bus.instruction_out}, 64'd0);
      check("rst_core_stall", {63'd0, bus.core_stall}, 64'd0);
      check("rst_load_done",  {63'd0, bus.load_done},  64'd0);
      check("rst_err_len",    {63'd0, bus.err_len},    64'd0);
      rst = 1'b1;
      step();

      // ---------------- table-driven loads ----------------
      foreach (vecs[v]) begin
         base = got_q.size();
         lat0 = lat_err;
         sh0  = stall_hi;
         rh0  = ready_hi;
         exp_words.delete();
         exp_words.push_back(vecs[v].w0);
         exp_words.push_back(vecs[v].w1);
         nsend = model_words(vecs[v].wc);

         do_start(vecs[v].wc);
         if (nsend == 0) begin
            check("imm_load_done", {63'd0, bus.load_done}, {63'd0, vecs[v].exp_done});
            check("imm_err_len",   {63'd0, bus.err_len},   {63'd0, vecs[v].exp_err});
         end
         for (int i = 0; i < nsend; i++) send_word(exp_words[i], vecs[v].gap);
         hold_then_idle();
         wait_pulses(base + vecs[v].exp_pulses);

         check("pulse_count", 64'(got_q.size() - base), 64'(vecs[v].exp_pulses));
         for (int i = 0; i < vecs[v].exp_pulses; i++) begin
            if (base + i < got_q.size()) check("word", {32'd0, got_q[base+i]}, {32'd0, exp_words[i]});
            else                         check("word_missing", 64'hDEAD, {32'd0, exp_words[i]});
         end
         check("load_done",  {63'd0, bus.load_done},  {63'd0, vecs[v].exp_done});
         check("err_len",    {63'd0, bus.err_len},    {63'd0, vecs[v].exp_err});
         check("core_stall_after", {63'd0, bus.core_stall}, 64'd0);
         check("host_ready_after", {63'd0, bus.host_ready}, 64'd0);
         check("strobe_timing", 64'(lat_err - lat0), 64'd0);
         if (vecs[v].exp_pulses == 0) begin
            check("no_stall",  64'(stall_hi - sh0), 64'd0);
            check("no_ready",  64'(ready_hi - rh0), 64'd0);
         end else begin
            check("instr_hold", {32'd0, bus.instruction_out},
                  {32'd0, exp_words[vecs[v].exp_pulses-1]});
         end
      end

      // ---------------- reset in the middle of a word ----------------
      do_start(1);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      #1;
      rst = 1'b0;
      #1;
      check("mid_rst_host_ready", {63'd0, bus.host_ready}, 64'd0);
      check("mid_rst_load_en",    {63'd0, bus.load_en},    64'd0);
      check("mid_rst_instr",      {32'd0, bus.instruction_out}, 64'd0);
      check("mid_rst_core_stall", {63'd0, bus.core_stall}, 64'd0);
      check("mid_rst_load_done",  {63'd0, bus.load_done},  64'd0);
      check("mid_rst_err_len",    {63'd0, bus.err_len},    64'd0);
      bus.host_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      check("post_rst_load_en",    {63'd0, bus.load_en},    64'd0);
      check("post_rst_core_stall", {63'd0, bus.core_stall}, 64'd0);
      check("post_rst_host_ready", {63'd0, bus.host_ready}, 64'd0);
      base = got_q.size();
      lat0 = lat_err;
      do_start(1);
      send_word(32'hAABBCCDD, 0);
      hold_then_idle();
      wait_pulses(base + 1);
      check("restart_pulses", 64'(got_q.size() - base), 64'd1);
      if (got_q.size() > base) check("restart_word", {32'd0, got_q[base]}, 64'hAABBCCDD);
      else                     check("restart_word_missing", 64'hDEAD, 64'hAABBCCDD);
      check("restart_timing", 64'(lat_err - lat0), 64'd0);

      // ---------------- full-length random load ----------------
      base = got_q.size();
      lat0 = lat_err;
      exp_words.delete();
      for (int i = 0; i < 1024; i++) exp_words.push_back($urandom);
      do_start(1024);
      s0 = stall_lo;
      for (int i = 0; i < 1024; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            // Spurious request while the load is running.
            bus.host_valid = 1'b0;
            bus.word_count = 11'($urandom_range(0, 2047));
            bus.start      = 1'b1;
            repeat ($urandom_range(1, 2)) step();
            bus.start      = 1'b0;
         end
         w = exp_words[i];
         for (int b = 0; b < 4; b++)
            send_byte(w[31-8*b -: 8], ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
      s1 = stall_lo;
      bus.host_valid = 1'b0;
      wait_pulses(base + 1024);
      check("rand_pulses", 64'(got_q.size() - base), 64'd1024);
      begin
         int bad;
         bad = 0;
         for (int i = 0; i < 1024; i++) begin
            if (base + i >= got_q.size() || got_q[base+i] !== exp_words[i]) begin
               if (bad < 4) check("rand_word", (base + i < got_q.size()) ? {32'd0, got_q[base+i]} : 64'hDEAD,
                                  {32'd0, exp_words[i]});
               bad++;
            end
         end
         check("rand_word_errors", 64'(bad), 64'd0);
      end
      check("rand_stall_gaps", 64'(s1 - s0), 64'd0);
      check("rand_timing",     64'(lat_err - lat0), 64'd0);
      check("rand_load_done",  {63'd0, bus.load_done}, 64'd1);
      check("rand_err_len",    {63'd0, bus.err_len},   64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter LINE_LENGTH, default 1024, instruction-buffer depth in 32-bit words.
REQ-002 Parameter BYTES_PER_WORD, default 4, host bytes per instruction.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to begin a program load; sampled in IDLE/DONE only.
REQ-006 word_count  input  [0:10]  number of instructions to load, 0..LINE_LENGTH; captured on accepted start.
REQ-007 host_byte  input  [0:7]  host data byte.
REQ-008 host_valid  input  1  host_byte valid this cycle.
REQ-009 host_ready  output  1  loader accepts host_byte this cycle; transfer when host_valid & host_ready.
REQ-010 load_en  output  1  one-cycle write strobe to the instruction buffer's load port.
REQ-011 instruction_out  output  [0:31]  assembled instruction, valid while load_en=1.
REQ-012 core_stall  output  1  holds fetch/PC while a load is in progress.
REQ-013 load_done  output  1  level; program fully written.
REQ-014 err_len  output  1  level; word_count exceeded LINE_LENGTH.

Function
REQ-015 FSM states IDLE, ASSEMBLE, EMIT, DONE; encoding free.
REQ-016 IDLE/DONE + start=1: capture word_count; if 0 -> DONE (load_done=1, no load_en); if >LINE_LENGTH -> DONE with err_len=1, load_done=0, no load_en; else -> ASSEMBLE, clear byte and word counters, clear load_done/err_len.
REQ-017 ASSEMBLE: host_ready=1; each transfer shifts byte in big-endian: first byte -> instruction bits [0:7], fourth -> [24:31].
REQ-018 Transfer of byte BYTES_PER_WORD-1 -> EMIT next cycle; word register complete.
REQ-019 EMIT: host_ready=0, load_en=1 for exactly one cycle, instruction_out = assembled word; word counter +1.
REQ-020 Latency: load_en asserted the cycle immediately after the last byte of a word is transferred.
REQ-021 EMIT -> ASSEMBLE if words emitted < captured count, else -> DONE.
REQ-022 DONE: load_done=1, core_stall=0, host_ready=0; stays until next accepted start.
REQ-023 core_stall=1 in ASSEMBLE and EMIT, 0 otherwise.
REQ-024 host_valid with host_ready=0: byte ignored, not consumed.
REQ-025 start asserted in ASSEMBLE/EMIT: ignored, no effect on counters.
REQ-026 Exactly captured-count load_en pulses per load; never more than LINE_LENGTH, so the buffer's write counter never wraps within one load.
REQ-027 Idle gaps (host_valid=0) of any length in ASSEMBLE preserve partial word and counters.
REQ-028 instruction_out holds last emitted word outside EMIT; load_en=0 outside EMIT.
REQ-029 A second program load requires the instruction buffer to be reset first; loader does not reset the buffer's write pointer.

Reset
REQ-030 rst=0 asynchronously forces IDLE; host_ready=0, load_en=0, instruction_out=0, core_stall=0, load_done=0, err_len=0, all counters 0.
REQ-031 Reset mid-load discards partial word; no load_en in the cycle after release; restart needs new start.

Structure
REQ-032 Shared package holds LINE_LENGTH, BYTES_PER_WORD, instruction width 32, and FSM state encoding, shared with the fetch block.
REQ-033 One sub-module natural: byte_assembler (shift register + byte counter, word_complete flag); FSM and word counter in top.

Verification
REQ-034 start, word_count=2, bytes 12 34 56 78 9A BC DE F0 back-to-back -> load_en pulses with 0x12345678 then 0x9ABCDEF0, each one cycle after its 4th byte; load_done=1 after second.
REQ-035 word_count=0 start -> load_done=1 next cycle, zero load_en, core_stall never 1.
REQ-036 word_count=1025 -> err_len=1, load_done=0, no load_en, host_ready stays 0.
REQ-037 word_count=1, host_valid gaps of 5 cycles between bytes, host_valid held high during EMIT -> single word correct, no byte lost or duplicated.
REQ-038 rst low after 2 bytes of word 0 -> all outputs 0 immediately; new start with 4 bytes 0xAABBCCDD -> first load_en carries 0xAABBCCDD.
REQ-039 word_count=1024 random bytes -> exactly 1024 load_en pulses, scoreboard match, core_stall high throughout, start pulses mid-load ignored.
